// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants, hazard FSM state encoding and NOP encoding
package pipeline_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_RS_LSB     = 21;
  localparam int DEF_RT_LSB     = 16;

  // sll r0,r0,0 is the canonical MIPS NOP loaded into ID/EX on a bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LU_STALL = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    LU_STALL = ST_LU_STALL,
    MEM_WAIT = ST_MEM_WAIT
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// rtl/pipeline_hazard_unit_if.sv - pipeline-side signals seen and driven by the hazard unit
interface pipeline_hazard_unit_if;

  logic        MemRead_ID_EX_out;
  logic [31:0] IR_ID_EX_out;
  logic [31:0] IR_IF_ID_out;
  logic        rs_used_IF_ID;
  logic        rt_used_IF_ID;
  logic        mem_ready;
  logic        branch_flush;
  logic        load_use_hazard;
  logic        PC_stall;
  logic        IF_ID_stall;
  logic        ID_EX_bubble;
  logic        ID_EX_stall;
  logic        EX_MEM_stall;
  logic        stall_busy;

  // pipeline datapath side: provides decode/memory status, obeys stall controls
  modport master (
    output MemRead_ID_EX_out, IR_ID_EX_out, IR_IF_ID_out,
    output rs_used_IF_ID, rt_used_IF_ID, mem_ready, branch_flush,
    input  load_use_hazard, PC_stall, IF_ID_stall, ID_EX_bubble,
    input  ID_EX_stall, EX_MEM_stall, stall_busy
  );

  // hazard unit side
  modport slave (
    input  MemRead_ID_EX_out, IR_ID_EX_out, IR_IF_ID_out,
    input  rs_used_IF_ID, rt_used_IF_ID, mem_ready, branch_flush,
    output load_use_hazard, PC_stall, IF_ID_stall, ID_EX_bubble,
    output ID_EX_stall, EX_MEM_stall, stall_busy
  );

endinterface

// File: rtl/hazard_compare.sv
// rtl/hazard_compare.sv - combinational load-use match between ID/EX load and IF/ID sources
module hazard_compare
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int RS_LSB     = DEF_RS_LSB,
  parameter int RT_LSB     = DEF_RT_LSB
) (
  input  logic        i_mem_read,
  input  logic [31:0] i_ir_id_ex,
  input  logic [31:0] i_ir_if_id,
  input  logic        i_rs_used,
  input  logic        i_rt_used,
  output logic        o_hit
);

  logic [REG_ADDR_W-1:0] w_load_rd;
  logic [REG_ADDR_W-1:0] w_rs;
  logic [REG_ADDR_W-1:0] w_rt;
  logic                  w_rd_nonzero;

  // a load writes its rt field; r0 is hardwired so it can never create a dependence
  assign w_load_rd    = i_ir_id_ex[RT_LSB +: REG_ADDR_W];
  assign w_rs         = i_ir_if_id[RS_LSB +: REG_ADDR_W];
  assign w_rt         = i_ir_if_id[RT_LSB +: REG_ADDR_W];
  assign w_rd_nonzero = |w_load_rd;

  // a field only matters when the consumer actually reads it
  assign o_hit = i_mem_read & w_rd_nonzero &
                 ((i_rs_used & (w_rs == w_load_rd)) |
                  (i_rt_used & (w_rt == w_load_rd)));

endmodule

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - load-use/memory-wait stall FSM; HAZARD_PERF_CNT_EN adds stall counters
module pipeline_hazard_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W        = DEF_REG_ADDR_W,
  parameter int RS_LSB            = DEF_RS_LSB,
  parameter int RT_LSB            = DEF_RT_LSB,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           lu_stall_cnt,
  output logic [31:0]           mem_stall_cnt
`endif
);

  hz_state_t  r_state;
  hz_state_t  r_saved;
  logic [3:0] r_cnt;

  hz_state_t  w_next_state;
  hz_state_t  w_next_saved;
  hz_state_t  w_eff;
  logic [3:0] w_next_cnt;
  logic       w_hit;
  logic       w_lu;
  logic       w_pc;
  logic       w_ifid;
  logic       w_bub;
  logic       w_idex;
  logic       w_exmem;

  hazard_compare #(
    .REG_ADDR_W (REG_ADDR_W),
    .RS_LSB     (RS_LSB),
    .RT_LSB     (RT_LSB)
  ) u_cmp (
    .i_mem_read (hz.MemRead_ID_EX_out),
    .i_ir_id_ex (hz.IR_ID_EX_out),
    .i_ir_if_id (hz.IR_IF_ID_out),
    .i_rs_used  (hz.rs_used_IF_ID),
    .i_rt_used  (hz.rt_used_IF_ID),
    .o_hit      (w_hit)
  );

  // next-state and stall decode; priority is memory wait, then flush, then load-use
  always_comb begin
    w_next_state = r_state;
    w_next_saved = r_saved;
    w_next_cnt   = r_cnt;
    w_lu         = 1'b0;
    w_pc         = 1'b0;
    w_ifid       = 1'b0;
    w_bub        = 1'b0;
    w_idex       = 1'b0;
    w_exmem      = 1'b0;
    // once memory is ready, MEM_WAIT behaves as the interrupted state in that same cycle
    w_eff        = (r_state == MEM_WAIT) ? r_saved : r_state;

    if (!hz.mem_ready) begin
      w_pc         = 1'b1;
      w_ifid       = 1'b1;
      w_idex       = 1'b1;
      w_exmem      = 1'b1;
      w_next_state = MEM_WAIT;
      w_next_saved = w_eff;
    end else if (hz.branch_flush) begin
      w_next_state = IDLE;
      w_next_saved = IDLE;
      w_next_cnt   = 4'd0;
    end else if (w_eff == LU_STALL) begin
      w_pc         = 1'b1;
      w_ifid       = 1'b1;
      w_bub        = 1'b1;
      w_next_cnt   = r_cnt - 4'd1;
      w_next_state = (r_cnt == 4'd1) ? IDLE : LU_STALL;
      w_next_saved = IDLE;
    end else if (w_hit) begin
      w_lu         = 1'b1;
      w_pc         = 1'b1;
      w_ifid       = 1'b1;
      w_bub        = 1'b1;
      w_next_saved = IDLE;
      if (LOAD_STALL_CYCLES > 1) begin
        w_next_state = LU_STALL;
        w_next_cnt   = 4'(LOAD_STALL_CYCLES - 1);
      end else begin
        w_next_state = IDLE;
      end
    end else begin
      w_next_state = IDLE;
      w_next_saved = IDLE;
    end
  end

  // state, saved-state and bubble counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_saved <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_saved <= w_next_saved;
      r_cnt   <= w_next_cnt;
    end
  end

  // outputs forced low while reset is held, independent of inputs
  assign hz.load_use_hazard = reset & w_lu;
  assign hz.PC_stall        = reset & w_pc;
  assign hz.IF_ID_stall     = reset & w_ifid;
  assign hz.ID_EX_bubble    = reset & w_bub;
  assign hz.ID_EX_stall     = reset & w_idex;
  assign hz.EX_MEM_stall    = reset & w_exmem;
  assign hz.stall_busy      = reset & (r_state != IDLE);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_lu_cnt;
  logic [31:0] r_mem_cnt;

  // free-running wrap-around event counters for bubble and memory-wait cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lu_cnt  <= 32'd0;
      r_mem_cnt <= 32'd0;
    end else begin
      if (w_bub) begin
        r_lu_cnt <= r_lu_cnt + 32'd1;
      end
      if (!hz.mem_ready || (r_state == MEM_WAIT)) begin
        r_mem_cnt <= r_mem_cnt + 32'd1;
      end
    end
  end

  assign lu_stall_cnt  = r_lu_cnt;
  assign mem_stall_cnt = r_mem_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb/tb_pipeline_hazard_unit.sv - directed bench for single- and triple-bubble hazard units
module tb_pipeline_hazard_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit_if if1 ();
  pipeline_hazard_unit_if if3 ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu1, mem1, lu3, mem3;
`endif

  pipeline_hazard_unit #(.LOAD_STALL_CYCLES(1)) u1 (
    .clk   (clk),
    .reset (rst_n),
    .hz    (if1)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .lu_stall_cnt  (lu1),
    .mem_stall_cnt (mem1)
`endif
  );

  pipeline_hazard_unit #(.LOAD_STALL_CYCLES(3)) u3 (
    .clk   (clk),
    .reset (rst_n),
    .hz    (if3)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .lu_stall_cnt  (lu3),
    .mem_stall_cnt (mem3)
`endif
  );

  // bit order: load_use_hazard, PC_stall, IF_ID_stall, ID_EX_bubble, ID_EX_stall, EX_MEM_stall, stall_busy
  wire [6:0] o1 = {if1.load_use_hazard, if1.PC_stall, if1.IF_ID_stall, if1.ID_EX_bubble,
                   if1.ID_EX_stall, if1.EX_MEM_stall, if1.stall_busy};
  wire [6:0] o3 = {if3.load_use_hazard, if3.PC_stall, if3.IF_ID_stall, if3.ID_EX_bubble,
                   if3.ID_EX_stall, if3.EX_MEM_stall, if3.stall_busy};

  localparam logic [6:0] Z    = 7'b0000000;
  localparam logic [6:0] HIT  = 7'b1111000;
  localparam logic [6:0] LU   = 7'b0111001;
  localparam logic [6:0] MWI  = 7'b0110110;
  localparam logic [6:0] MWB  = 7'b0110111;
  localparam logic [6:0] BUSY = 7'b0000001;

  function automatic logic [31:0] mk_ir(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h23, rs, rt, 16'h0000};
  endfunction

  task automatic drive(input logic mr, input logic [31:0] irex, input logic [31:0] irif,
                       input logic rsu, input logic rtu, input logic rdy, input logic fl);
    if1.MemRead_ID_EX_out = mr;  if3.MemRead_ID_EX_out = mr;
    if1.IR_ID_EX_out      = irex; if3.IR_ID_EX_out     = irex;
    if1.IR_IF_ID_out      = irif; if3.IR_IF_ID_out     = irif;
    if1.rs_used_IF_ID     = rsu; if3.rs_used_IF_ID     = rsu;
    if1.rt_used_IF_ID     = rtu; if3.rt_used_IF_ID     = rtu;
    if1.mem_ready         = rdy; if3.mem_ready         = rdy;
    if1.branch_flush      = fl;  if3.branch_flush      = fl;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // inputs are already applied at a falling edge; check mid-low-phase, then move to next falling edge
  task automatic cyc(input string tag, input logic [6:0] e1, input logic [6:0] e3);
    #1;
    chk({tag, "/u1"}, o1, e1);
    chk({tag, "/u3"}, o3, e3);
    @(negedge clk);
  endtask

  task automatic idle_in();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic hit_in();
    drive(1'b1, mk_ir(5'd0, 5'd8), mk_ir(5'd8, 5'd3), 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b1, mk_ir(5'd0, 5'd8), mk_ir(5'd8, 5'd3), 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    cyc("reset_held", Z, Z);
    rst_n = 1'b1;
    idle_in();
    cyc("idle", Z, Z);

    // rs load-use hazard: one bubble for u1, three for u3
    hit_in();
    cyc("rs_hit_c0", HIT, HIT);
    idle_in();
    cyc("rs_hit_c1", Z, LU);
    cyc("rs_hit_c2", Z, LU);
    cyc("rs_hit_c3", Z, Z);
`ifdef HAZARD_PERF_CNT_EN
    chk32("lu_cnt_u1", lu1, 32'd1);
    chk32("lu_cnt_u3", lu3, 32'd3);
    chk32("mem_cnt_u3", mem3, 32'd0);
`endif

    // r0 destination and unused fields never hazard
    drive(1'b1, mk_ir(5'd0, 5'd0), mk_ir(5'd0, 5'd0), 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("rd_zero", Z, Z);
    drive(1'b1, mk_ir(5'd0, 5'd8), mk_ir(5'd5, 5'd8), 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("rt_unused", Z, Z);
    drive(1'b1, mk_ir(5'd0, 5'd8), mk_ir(5'd8, 5'd3), 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("rs_unused", Z, Z);
    drive(1'b0, mk_ir(5'd0, 5'd8), mk_ir(5'd8, 5'd8), 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("no_load", Z, Z);

    // rt load-use hazard
    drive(1'b1, mk_ir(5'd0, 5'd8), mk_ir(5'd5, 5'd8), 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("rt_hit_c0", HIT, HIT);
    idle_in();
    cyc("rt_hit_c1", Z, LU);
    cyc("rt_hit_c2", Z, LU);
    cyc("rt_hit_c3", Z, Z);

    // memory wait after the first bubble: frozen count, then two more bubbles
    hit_in();
    cyc("mw_c0", HIT, HIT);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("mw_c1", MWI, MWB);
    cyc("mw_c2", MWB, MWB);
    idle_in();
    cyc("mw_c3", BUSY, LU);
    cyc("mw_c4", Z, LU);
    cyc("mw_c5", Z, Z);

    // flush coincident with hazard, then flush during LU_STALL
    drive(1'b1, mk_ir(5'd0, 5'd8), mk_ir(5'd8, 5'd3), 1'b1, 1'b0, 1'b1, 1'b1);
    cyc("flush_same", Z, Z);
    idle_in();
    cyc("flush_same_after", Z, Z);
    hit_in();
    cyc("flush_lu_c0", HIT, HIT);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc("flush_lu_c1", Z, BUSY);
    idle_in();
    cyc("flush_lu_c2", Z, Z);

    // asynchronous reset in the middle of LU_STALL
    hit_in();
    cyc("rst_c0", HIT, HIT);
    idle_in();
    #1;
    chk("rst_c1_pre/u3", o3, LU);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async/u1", o1, Z);
    chk("rst_async/u3", o3, Z);
`ifdef HAZARD_PERF_CNT_EN
    chk32("lu_cnt_clr_u1", lu1, 32'd0);
    chk32("lu_cnt_clr_u3", lu3, 32'd0);
    chk32("mem_cnt_clr_u3", mem3, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cyc("rst_after_c0", Z, Z);
    cyc("rst_after_c1", Z, Z);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
